// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache memory-port arbiter.
package cache_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_t;

  localparam int unsigned PERF_CNT_W = 32;

  typedef struct packed {
    logic [PERF_CNT_W-1:0] p0_grants;
    logic [PERF_CNT_W-1:0] p1_grants;
    logic [PERF_CNT_W-1:0] stall_cycles;
  } perf_cnt_t;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of issuing port IDs for granted, not yet answered transactions.
module arb_id_fifo
  import cache_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  port_id_t din,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = port_id_t'(mem_q[rd_ptr_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-requester round-robin arbiter with request locking and in-order response routing.
// Optional performance counters: define CACHE_ARB_PERF_CNT_EN.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  output logic                    p0_error_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    p1_error_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_error_i,
  output logic                    unexpected_rvalid_o
`ifdef CACHE_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]   perf_p0_grants_o,
  output logic [PERF_CNT_W-1:0]   perf_p1_grants_o,
  output logic [PERF_CNT_W-1:0]   perf_stall_cycles_o
`endif
);

  lock_state_t state_q, state_d;
  port_id_t    lock_port_q, rr_pref_q, sel_port, fifo_head;
  logic        sel_req, xfer, fifo_full, fifo_empty, unexpected_q;

  // State register: lock state, locked port, round-robin preference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_OPEN;
      lock_port_q <= PORT0;
      rr_pref_q   <= PORT0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_OPEN && state_d == ARB_LOCKED) begin
        lock_port_q <= sel_port;
      end
      if (xfer) begin
        rr_pref_q <= other_port(sel_port);
      end
    end
  end

  // Next state: an ungranted request pins the selection until its grant.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = ARB_OPEN;
    end else if (mem_req_o) begin
      state_d = ARB_LOCKED;
    end
  end

  // Output logic: port selection and memory-side mux.
  always_comb begin
    sel_port    = PORT0;
    sel_req     = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (state_q == ARB_LOCKED) begin
      sel_port = lock_port_q;
      sel_req  = (lock_port_q == PORT0) ? p0_req_i : p1_req_i;
    end else if (p0_req_i && p1_req_i) begin
      sel_port = rr_pref_q;
      sel_req  = 1'b1;
    end else if (p1_req_i) begin
      sel_port = PORT1;
      sel_req  = 1'b1;
    end else begin
      sel_req  = p0_req_i;
    end
    // Outputs read as idle while reset is held, even with requests pending.
    sel_req = sel_req & rst_n;
    if (sel_req) begin
      if (sel_port == PORT0) begin
        mem_addr_o  = p0_addr_i;
        mem_we_o    = p0_we_i;
        mem_be_o    = p0_be_i;
        mem_wdata_o = p0_wdata_i;
      end else begin
        mem_addr_o  = p1_addr_i;
        mem_we_o    = p1_we_i;
        mem_be_o    = p1_be_i;
        mem_wdata_o = p1_wdata_i;
      end
    end
  end

  assign mem_req_o = sel_req & ~fifo_full;
  assign xfer      = mem_req_o & mem_gnt_i;
  assign p0_gnt_o  = xfer & (sel_port == PORT0);
  assign p1_gnt_o  = xfer & (sel_port == PORT1);

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer),
    .pop   (mem_rvalid_i & ~fifo_empty),
    .din   (sel_port),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign p0_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == PORT0);
  assign p1_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == PORT1);
  assign p0_rdata_o  = (~fifo_empty && fifo_head == PORT0) ? mem_rdata_i : '0;
  assign p1_rdata_o  = (~fifo_empty && fifo_head == PORT1) ? mem_rdata_i : '0;
  assign p0_error_o  = ~fifo_empty & (fifo_head == PORT0) & mem_error_i;
  assign p1_error_o  = ~fifo_empty & (fifo_head == PORT1) & mem_error_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unexpected_q <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      unexpected_q <= 1'b1;
    end
  end

  assign unexpected_rvalid_o = unexpected_q;

`ifdef CACHE_ARB_PERF_CNT_EN
  perf_cnt_t perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      if (p0_gnt_o) perf_q.p0_grants <= sat_inc(perf_q.p0_grants);
      if (p1_gnt_o) perf_q.p1_grants <= sat_inc(perf_q.p1_grants);
      if ((p0_req_i || p1_req_i) && !xfer) begin
        perf_q.stall_cycles <= sat_inc(perf_q.stall_cycles);
      end
    end
  end

  assign perf_p0_grants_o    = perf_q.p0_grants;
  assign perf_p1_grants_o    = perf_q.p1_grants;
  assign perf_stall_cycles_o = perf_q.stall_cycles;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bench for cache_mem_arbiter against a queue-based reference model.
module tb_cache_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [AW-1:0] addr  [2];
  logic          we    [2];
  logic [BW-1:0] be    [2];
  logic [DW-1:0] wdata [2];
  logic          mem_gnt, mem_rvalid, mem_error;
  logic [DW-1:0] mem_rdata;

  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_error, p1_error;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata;
  logic          mem_req, mem_we, unexp;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: outstanding IDs in issue order, preferred port, pinned port.
  int q[$];
  int pref;
  bit lock_v;
  int lock_p;
  bit unexp_m;
  bit gnt_m [2];
  bit held  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .p0_req_i            (req[0]),
    .p0_gnt_o            (p0_gnt),
    .p0_rvalid_o         (p0_rvalid),
    .p0_addr_i           (addr[0]),
    .p0_we_i             (we[0]),
    .p0_be_i             (be[0]),
    .p0_wdata_i          (wdata[0]),
    .p0_rdata_o          (p0_rdata),
    .p0_error_o          (p0_error),
    .p1_req_i            (req[1]),
    .p1_gnt_o            (p1_gnt),
    .p1_rvalid_o         (p1_rvalid),
    .p1_addr_i           (addr[1]),
    .p1_we_i             (we[1]),
    .p1_be_i             (be[1]),
    .p1_wdata_i          (wdata[1]),
    .p1_rdata_o          (p1_rdata),
    .p1_error_o          (p1_error),
    .mem_req_o           (mem_req),
    .mem_gnt_i           (mem_gnt),
    .mem_rvalid_i        (mem_rvalid),
    .mem_addr_o          (mem_addr),
    .mem_we_o            (mem_we),
    .mem_be_o            (mem_be),
    .mem_wdata_o         (mem_wdata),
    .mem_rdata_i         (mem_rdata),
    .mem_error_i         (mem_error),
    .unexpected_rvalid_o (unexp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req        = 2'b00;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_error  = 1'b0;
    mem_rdata  = '0;
    for (int p = 0; p < 2; p++) begin
      addr[p]  = '0;
      we[p]    = 1'b0;
      be[p]    = '0;
      wdata[p] = '0;
    end
  endtask

  // Called shortly after a rising edge with inputs applied; checks at the
  // falling edge, then advances the model across the next rising edge.
  task automatic cycle(input string tag);
    int sel;
    bit sreq, emreq, rv;
    int head;
    if (lock_v) begin
      sel = lock_p; sreq = req[lock_p];
    end else if (req == 2'b11) begin
      sel = pref; sreq = 1'b1;
    end else if (req[1]) begin
      sel = 1; sreq = 1'b1;
    end else begin
      sel = 0; sreq = req[0];
    end
    emreq = sreq && (q.size() < DEPTH);
    head  = (q.size() > 0) ? q[0] : -1;
    rv    = mem_rvalid && (head >= 0);
    @(negedge clk);
    chk({tag, ".mem_req"},   mem_req,   emreq);
    chk({tag, ".p0_gnt"},    p0_gnt,    emreq && mem_gnt && sel == 0);
    chk({tag, ".p1_gnt"},    p1_gnt,    emreq && mem_gnt && sel == 1);
    chk({tag, ".mem_addr"},  mem_addr,  sreq ? addr[sel] : '0);
    chk({tag, ".mem_we"},    mem_we,    sreq ? we[sel] : 1'b0);
    chk({tag, ".mem_be"},    mem_be,    sreq ? be[sel] : '0);
    chk({tag, ".mem_wdata"}, mem_wdata, sreq ? wdata[sel] : '0);
    chk({tag, ".p0_rvalid"}, p0_rvalid, rv && head == 0);
    chk({tag, ".p1_rvalid"}, p1_rvalid, rv && head == 1);
    chk({tag, ".p0_rdata"},  p0_rdata,  (head == 0) ? mem_rdata : '0);
    chk({tag, ".p1_rdata"},  p1_rdata,  (head == 1) ? mem_rdata : '0);
    chk({tag, ".p0_error"},  p0_error,  (head == 0) && mem_error);
    chk({tag, ".p1_error"},  p1_error,  (head == 1) && mem_error);
    chk({tag, ".unexp"},     unexp,     unexp_m);
    @(posedge clk);
    gnt_m[0] = 1'b0;
    gnt_m[1] = 1'b0;
    if (mem_rvalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else unexp_m = 1'b1;
    end
    if (emreq && mem_gnt) begin
      q.push_back(sel);
      pref       = 1 - sel;
      lock_v     = 1'b0;
      gnt_m[sel] = 1'b1;
    end else if (emreq) begin
      lock_v = 1'b1;
      lock_p = sel;
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #3;
    chk({tag, ".mem_req"},   mem_req,   1'b0);
    chk({tag, ".p0_gnt"},    p0_gnt,    1'b0);
    chk({tag, ".p1_gnt"},    p1_gnt,    1'b0);
    chk({tag, ".p0_rvalid"}, p0_rvalid, 1'b0);
    chk({tag, ".p1_rvalid"}, p1_rvalid, 1'b0);
    chk({tag, ".p0_rdata"},  p0_rdata,  '0);
    chk({tag, ".p1_rdata"},  p1_rdata,  '0);
    chk({tag, ".p0_error"},  p0_error,  1'b0);
    chk({tag, ".p1_error"},  p1_error,  1'b0);
    chk({tag, ".mem_addr"},  mem_addr,  '0);
    chk({tag, ".unexp"},     unexp,     1'b0);
    q.delete();
    pref    = 0;
    lock_v  = 1'b0;
    lock_p  = 0;
    unexp_m = 1'b0;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    do_reset("reset");

    // Port0 write, granted in the same cycle, then its response.
    req[0] = 1'b1; addr[0] = 32'h0010_0000; we[0] = 1'b1;
    be[0] = 4'hF; wdata[0] = 32'h1234_ABCD; mem_gnt = 1'b1;
    #3;
    chk("t1.p0_gnt_c", p0_gnt, 1'b1);
    chk("t1.we_c", mem_we, 1'b1);
    chk("t1.addr_c", mem_addr, 32'h0010_0000);
    cycle("t1a");
    req = 2'b00; mem_gnt = 1'b0;
    cycle("t1b");
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #3;
    chk("t1.p0_rv_c", p0_rvalid, 1'b1);
    chk("t1.p1_rv_c", p1_rvalid, 1'b0);
    chk("t1.p0_rdata_c", p0_rdata, 32'hCAFE_0001);
    cycle("t1c");
    mem_rvalid = 1'b0;

    // Both ports stream reads: grants alternate starting from port0.
    do_reset("rst2");
    req = 2'b11; addr[0] = 32'h0010_0200; addr[1] = 32'h0010_0300;
    be[0] = 4'hF; be[1] = 4'hF; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = (k > 0);
      mem_rdata  = 32'h100 + k;
      #3;
      chk("t2.p0_gnt_c", p0_gnt, (k % 2) == 0);
      chk("t2.p1_gnt_c", p1_gnt, (k % 2) == 1);
      chk("t2.p0_rv_c", p0_rvalid, (k > 0) && ((k - 1) % 2 == 0));
      chk("t2.p1_rv_c", p1_rvalid, (k > 0) && ((k - 1) % 2 == 1));
      cycle("t2");
    end
    req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #3;
    chk("t2.last_p1_rv_c", p1_rvalid, 1'b1);
    cycle("t2e");
    mem_rvalid = 1'b0;

    // Port1 stalls without grant; port0 joins but cannot steal the locked slot.
    req = 2'b10;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) req[0] = 1'b1;
      mem_gnt = (c == 3);
      #3;
      chk("t3.addr_c", mem_addr, 32'h0010_0300);
      chk("t3.p1_gnt_c", p1_gnt, c == 3);
      chk("t3.p0_gnt_c", p0_gnt, 1'b0);
      cycle("t3");
    end
    req[1] = 1'b0;
    #3;
    chk("t3.p0_next_c", p0_gnt, 1'b1);
    chk("t3.p0_addr_c", mem_addr, 32'h0010_0200);
    cycle("t3n");

    // Two outstanding: request gated; pop frees a slot one cycle later.
    addr[0] = 32'h0010_0400;
    #3;
    chk("t4.full_req_c", mem_req, 1'b0);
    cycle("t4a");
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_0001;
    #3;
    chk("t4.full_pop_req_c", mem_req, 1'b0);
    chk("t4.p1_rv_c", p1_rvalid, 1'b1);
    cycle("t4b");
    #3;
    chk("t4.pushpop_req_c", mem_req, 1'b1);
    chk("t4.pushpop_gnt_c", p0_gnt, 1'b1);
    chk("t4.pushpop_rv_c", p0_rvalid, 1'b1);
    cycle("t4c");
    req = 2'b00; mem_gnt = 1'b0;
    #3;
    chk("t4.last_rv_c", p0_rvalid, 1'b1);
    cycle("t4d");

    // Response with nothing outstanding.
    #3;
    chk("t5.p0_rv_c", p0_rvalid, 1'b0);
    chk("t5.p1_rv_c", p1_rvalid, 1'b0);
    cycle("t5a");
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("t5.sticky_c", unexp, 1'b1);
      cycle("t5s");
    end

    // Reset with two outstanding and inputs still active.
    req = 2'b11; mem_gnt = 1'b1;
    cycle("t6a");
    cycle("t6b");
    mem_rvalid = 1'b1;
    do_reset("t6rst");
    mem_rvalid = 1'b1;
    cycle("t6late");
    mem_rvalid = 1'b0;
    req[0] = 1'b1; addr[0] = 32'h0010_0500; mem_gnt = 1'b1;
    #3;
    chk("t6.p0_gnt_c", p0_gnt, 1'b1);
    chk("t6.unexp_c", unexp, 1'b1);
    cycle("t6g");
    req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    cycle("t6r");
    mem_rvalid = 1'b0;

    // Randomized traffic obeying the hold-until-grant protocol.
    do_reset("rst_rnd");
    held[0] = 1'b0;
    held[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!held[p]) begin
          req[p] = ($urandom_range(0, 2) != 0);
          if (req[p]) begin
            addr[p]  = $urandom;
            we[p]    = $urandom_range(0, 1) == 1;
            be[p]    = 4'($urandom);
            wdata[p] = $urandom;
          end
          held[p] = req[p];
        end
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      mem_error  = ($urandom_range(0, 7) == 0);
      cycle("rnd");
      for (int p = 0; p < 2; p++) begin
        if (gnt_m[p]) held[p] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
